// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: VGA scanout reads, buffered writer requests and a
// full-screen clear engine sharing one single-port video RAM.
module fb_arbiter #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 15
) (
  input  logic              CLOCK_25,
  input  logic              rst_n,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  input  logic              disp_active,
  output logic [7:0]        R_out,
  output logic [7:0]        G_out,
  output logic [7:0]        B_out,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [7:0]        wr_data,
  input  logic              clr_req,
  input  logic [7:0]        clr_color,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int LAST_I = FB_W * FB_H - 1;
  localparam int SS     = SCALE_SHIFT;
  localparam logic [ADDR_W-1:0] LAST = LAST_I[ADDR_W-1:0];
  localparam logic [PW:0]       FULL_N = FIFO_DEPTH[PW:0];
  localparam logic [7:0]        W8 = FB_W[7:0];
  localparam logic [6:0]        H7 = FB_H[6:0];

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;

  // y*160 + x built from shifts, fixed to the 160-word row pitch
  function automatic logic [ADDR_W-1:0] fb_addr(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [ADDR_W-1:0] ye;
    ye = ADDR_W'(y);
    return (ye << 7) + (ye << 5) + ADDR_W'(x);
  endfunction

  logic              act_q1, act_q2, rd_q;
  logic [7:0]        pix_q;
  logic              rd_slot;
  logic [ADDR_W-1:0] rd_addr, last_q;
  logic [7:0]        clr_color_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              clr_done_q, clr_last;

  logic [22:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       cnt;
  logic              push, pop, full;
  logic [7:0]        hx, hd;
  logic [6:0]        hy;
  logic              in_range;

  assign rd_slot = disp_active && (disp_x[1:0] == 2'd0 || !act_q1);
  assign rd_addr = fb_addr(8'(disp_x >> SS), 8'(disp_y >> SS));

  assign full     = (cnt == FULL_N);
  assign wr_ready = !full && state_q == IDLE;
  assign push     = wr_valid && wr_ready;
  assign pop      = !rd_slot && state_q == IDLE && cnt != '0;
  assign {hx, hy, hd} = fifo_q[rd_ptr];
  assign in_range = (hx < W8) && (hy < H7);

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;

  assign R_out = act_q2 ? {pix_q[7:5], pix_q[7:5], pix_q[7:6]} : 8'h00;
  assign G_out = act_q2 ? {pix_q[4:2], pix_q[4:2], pix_q[4:3]} : 8'h00;
  assign B_out = act_q2 ? {4{pix_q[1:0]}} : 8'h00;

  always_comb begin
    state_d   = state_q;
    clr_last  = 1'b0;
    mem_addr  = last_q;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (rd_slot) begin
      mem_addr = rd_addr;
    end else if (state_q == CLEAR) begin
      mem_addr  = clr_addr_q;
      mem_we    = 1'b1;
      mem_wdata = clr_color_q;
      if (clr_addr_q == LAST) begin
        state_d  = IDLE;
        clr_last = 1'b1;
      end
    end else if (cnt != '0) begin
      mem_addr  = fb_addr(hx, {1'b0, hy});
      mem_we    = in_range;
      mem_wdata = hd;
    end
    if (state_q == IDLE && clr_req) state_d = CLEAR;
    if (!rst_n) begin
      mem_addr = '0;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_q1      <= 1'b0;
      act_q2      <= 1'b0;
      rd_q        <= 1'b0;
      pix_q       <= 8'h00;
      last_q      <= '0;
      clr_color_q <= 8'h00;
      clr_addr_q  <= '0;
      clr_done_q  <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      state_q    <= state_d;
      act_q1     <= disp_active;
      act_q2     <= act_q1;
      rd_q       <= rd_slot;
      last_q     <= mem_addr;
      clr_done_q <= clr_last;
      if (rd_q) pix_q <= mem_rdata;
      if (state_q == IDLE && clr_req) begin
        clr_color_q <= clr_color;
        clr_addr_q  <= '0;
      end else if (state_q == CLEAR && !rd_slot) begin
        clr_addr_q <= clr_addr_q + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (push) fifo_q[wr_ptr] <= {wr_x, wr_y, wr_data};
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a 1-cycle-latency RAM model.
module tb_fb_arbiter;

  logic        CLOCK_25 = 1'b0;
  logic        rst_n;
  logic [9:0]  disp_x, disp_y;
  logic        disp_active;
  logic [7:0]  R_out, G_out, B_out;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [7:0]  wr_data;
  logic        clr_req;
  logic [7:0]  clr_color;
  logic        busy, clr_done;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  ram [0:32767] = '{default: 8'h00};
  logic        tb_we = 1'b0;
  logic [14:0] tb_addr = '0;
  logic [7:0]  tb_data = '0;
  logic [23:0] rgb;

  int passed = 0;
  int total  = 0;

  assign rgb = {R_out, G_out, B_out};

  always #20 CLOCK_25 = ~CLOCK_25;

  always @(posedge CLOCK_25) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  fb_arbiter dut (
    .CLOCK_25(CLOCK_25), .rst_n(rst_n),
    .disp_x(disp_x), .disp_y(disp_y), .disp_active(disp_active),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr_req(clr_req), .clr_color(clr_color),
    .busy(busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge CLOCK_25);
    total++; if ({mem_we, busy, clr_done} !== 3'b000) $display("FAIL rst_ctl got %b want 000", {mem_we, busy, clr_done}); else passed++;
    total++; if (rgb !== 24'h0) $display("FAIL rst_rgb got %h want 000000", rgb); else passed++;
    total++; if (mem_addr !== 15'd0) $display("FAIL rst_addr got %0d want 0", mem_addr); else passed++;
    tick();
    rst_n = 1'b1;
    @(negedge CLOCK_25);
    total++; if (wr_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", wr_ready); else passed++;
    total++; if ({mem_we, busy} !== 2'b00) $display("FAIL idle_ctl got %b want 00", {mem_we, busy}); else passed++;
    total++; if (rgb !== 24'h0) $display("FAIL idle_rgb got %h want 000000", rgb); else passed++;
    tick();
  endtask

  task automatic test_read();
    logic [23:0] exp_rgb;
    tb_we = 1'b1; tb_addr = 15'd161; tb_data = 8'hE0;
    tick();
    tb_addr = 15'd162; tb_data = 8'h1C;
    tick();
    tb_we = 1'b0;
    tick();
    for (int c = 0; c < 12; c++) begin
      disp_active = (c < 8);
      disp_x = 10'(4 + c);
      disp_y = 10'd4;
      @(negedge CLOCK_25);
      if (c == 0) begin
        total++; if (mem_addr !== 15'd161) $display("FAIL rd_addr0 got %0d want 161", mem_addr); else passed++;
      end
      if (c == 4) begin
        total++; if (mem_addr !== 15'd162) $display("FAIL rd_addr4 got %0d want 162", mem_addr); else passed++;
      end
      if (c >= 2 && c <= 5)      exp_rgb = 24'hFF0000;
      else if (c >= 6 && c <= 9) exp_rgb = 24'h00FF00;
      else                       exp_rgb = 24'h000000;
      total++; if (rgb !== exp_rgb || mem_we !== 1'b0) $display("FAIL rd_rgb c=%0d got %h we=%b want %h we=0", c, rgb, mem_we, exp_rgb); else passed++;
      tick();
    end
  endtask

  task automatic test_fifo_full();
    logic [14:0] exp_a [5];
    exp_a = '{15'd160, 15'd323, 15'd486, 15'd649, 15'd812};
    disp_active = 1'b1; disp_x = 10'd0; disp_y = 10'd0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_x = 8'(i * 3); wr_y = 7'(i + 1); wr_data = 8'(8'h10 + i);
      @(negedge CLOCK_25);
      total++; if (wr_ready !== (i < 4)) $display("FAIL ff_ready i=%0d got %b want %b", i, wr_ready, i < 4); else passed++;
      total++; if (mem_we !== 1'b0) $display("FAIL ff_rdslot_we i=%0d got %b want 0", i, mem_we); else passed++;
      tick();
    end
    disp_x = 10'd1;
    @(negedge CLOCK_25);
    total++; if (wr_ready !== 1'b0) $display("FAIL ff_full_ready got %b want 0", wr_ready); else passed++;
    total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd160, 8'h10}) $display("FAIL ff_pop0 got we=%b a=%0d d=%h want we=1 a=160 d=10", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    @(negedge CLOCK_25);
    total++; if (wr_ready !== 1'b1) $display("FAIL ff_unstall got %b want 1", wr_ready); else passed++;
    total++; if (mem_addr !== 15'd323) $display("FAIL ff_pop1 got %0d want 323", mem_addr); else passed++;
    tick();
    wr_valid = 1'b0; disp_active = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (ram[exp_a[i]] !== 8'(8'h10 + i)) $display("FAIL ff_ram i=%0d got %h want %h", i, ram[exp_a[i]], 8'(8'h10 + i)); else passed++;
    end
  endtask

  task automatic test_bounds();
    disp_active = 1'b0;
    wr_valid = 1'b1; wr_x = 8'd159; wr_y = 7'd119; wr_data = 8'h03;
    tick();
    wr_x = 8'd160; wr_y = 7'd0; wr_data = 8'h55;
    @(negedge CLOCK_25);
    total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd19199, 8'h03}) $display("FAIL bd_last got we=%b a=%0d d=%h want we=1 a=19199 d=03", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    wr_valid = 1'b0;
    @(negedge CLOCK_25);
    total++; if ({mem_we, wr_ready} !== 2'b01) $display("FAIL bd_oor got we,ready=%b want 01", {mem_we, wr_ready}); else passed++;
    tick();
    wr_valid = 1'b1; wr_x = 8'd1; wr_y = 7'd0; wr_data = 8'hAA;
    tick();
    wr_valid = 1'b0;
    @(negedge CLOCK_25);
    total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd1, 8'hAA}) $display("FAIL bd_next got we=%b a=%0d d=%h want we=1 a=1 d=aa", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    disp_active = 1'b1; disp_x = 10'd636; disp_y = 10'd476;
    @(negedge CLOCK_25);
    total++; if (mem_addr !== 15'd19199) $display("FAIL bd_rd_addr got %0d want 19199", mem_addr); else passed++;
    tick();
    disp_active = 1'b0;
    tick();
    @(negedge CLOCK_25);
    total++; if (rgb !== 24'h0000FF) $display("FAIL bd_blue got %h want 0000ff", rgb); else passed++;
    tick();
  endtask

  task automatic test_clear();
    int nb = 0, nd = 0, errs = 0, bad = 0, k_done = 0;
    disp_active = 1'b0; wr_valid = 1'b0;
    clr_req = 1'b1; clr_color = 8'h1C;
    @(negedge CLOCK_25);
    total++; if (busy !== 1'b0) $display("FAIL cl_pre_busy got %b want 0", busy); else passed++;
    tick();
    clr_color = 8'hE0;
    for (int k = 1; k < 20000; k++) begin
      clr_req = (k == 5000);
      @(negedge CLOCK_25);
      if (busy) begin
        nb++;
        if (!mem_we || mem_addr != 15'(nb - 1) || mem_wdata != 8'h1C) errs++;
      end
      if (clr_done) begin
        nd++;
        if (k_done == 0) k_done = k;
      end
      if (k == 100) begin
        total++; if (wr_ready !== 1'b0) $display("FAIL cl_ready got %b want 0", wr_ready); else passed++;
      end
      tick();
      if (k_done != 0 && k > k_done + 3) break;
    end
    clr_req = 1'b0;
    for (int a = 0; a < 19200; a++) if (ram[a] !== 8'h1C) bad++;
    total++; if (nb !== 19200) $display("FAIL cl_busy_cycles got %0d want 19200", nb); else passed++;
    total++; if (nd !== 1) $display("FAIL cl_done_pulses got %0d want 1", nd); else passed++;
    total++; if (k_done !== 19201) $display("FAIL cl_done_cycle got %0d want 19201", k_done); else passed++;
    total++; if (errs !== 0) $display("FAIL cl_write_seq got %0d bad cycles want 0", errs); else passed++;
    total++; if (bad !== 0) $display("FAIL cl_ram got %0d bad words want 0", bad); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL cl_post_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_clear_fifo();
    bit seen = 0;
    disp_active = 1'b1; disp_x = 10'd0; disp_y = 10'd0;
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd5; wr_data = 8'hE3;
    tick();
    wr_x = 8'd7; wr_y = 7'd7; wr_data = 8'h1F;
    tick();
    wr_valid = 1'b0; clr_req = 1'b1; clr_color = 8'h00;
    tick();
    clr_req = 1'b0; disp_active = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge CLOCK_25);
      if (clr_done) begin
        seen = 1;
        total++; if ({ram[805], ram[1127]} !== 16'h0000) $display("FAIL cf_cleared got %h %h want 00 00", ram[805], ram[1127]); else passed++;
      end
      tick();
    end
    total++; if (!seen) $display("FAIL cf_timeout got no clr_done want clr_done"); else passed++;
    repeat (3) tick();
    total++; if ({ram[805], ram[1127]} !== 16'hE31F) $display("FAIL cf_landed got %h %h want e3 1f", ram[805], ram[1127]); else passed++;
  endtask

  task automatic test_reset_mid();
    int we_cnt = 0;
    disp_active = 1'b1; disp_x = 10'd0; disp_y = 10'd0;
    wr_valid = 1'b1; wr_x = 8'd2; wr_y = 7'd2; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0; clr_req = 1'b1; clr_color = 8'h44;
    tick();
    clr_req = 1'b0; disp_active = 1'b0;
    repeat (100) tick();
    @(negedge CLOCK_25);
    total++; if (busy !== 1'b1) $display("FAIL rm_busy_pre got %b want 1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({busy, mem_we, mem_addr} !== 17'd0) $display("FAIL rm_abort got busy=%b we=%b a=%0d want 0 0 0", busy, mem_we, mem_addr); else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK_25);
      if (mem_we) we_cnt++;
      if (k == 0) begin
        total++; if ({wr_ready, busy} !== 2'b10) $display("FAIL rm_after got ready,busy=%b want 10", {wr_ready, busy}); else passed++;
      end
      tick();
    end
    total++; if (we_cnt !== 0) $display("FAIL rm_fifo_empty got %0d writes want 0", we_cnt); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; disp_x = '0; disp_y = '0; disp_active = 1'b0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    clr_req = 1'b0; clr_color = '0;
    test_reset();
    test_read();
    test_fifo_full();
    test_bounds();
    test_clear();
    test_clear_fifo();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
